// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: FSM state enum, slave register offsets and opcode/done constants for alu_job_scheduler
package alu_sched_pkg;
  typedef enum logic [3:0] {IDLE, WR_A, WR_B, WR_OP, WR_START, POLL, RD_LO, RD_HI, CLR, RESP} state_t;
  localparam logic [2:0] OFS_A = 3'd0;
  localparam logic [2:0] OFS_B = 3'd1;
  localparam logic [2:0] OFS_OP = 3'd2;
  localparam logic [2:0] OFS_START = 3'd3;
  localparam logic [2:0] OFS_DONE = 3'd4;
  localparam logic [2:0] OFS_CLR = 3'd5;
  localparam logic [2:0] OFS_RLO = 3'd6;
  localparam logic [2:0] OFS_RHI = 3'd7;
  localparam logic [3:0] OPC_MUL = 4'hD;
  localparam logic [1:0] DONE_FIN = 2'b11;
endpackage

// File: rtl/alu_job_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter; req/adv in, one-hot grant and any out, pointer moves past the winner on adv
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  output logic [N_REQ-1:0] grant,
  output logic             any
);
  logic [1:0] p;
  logic [1:0] win;
  logic found;
  int idx;
  assign any = |req;
  always_comb begin
    grant = '0;
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        win = idx[1:0];
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) p <= '0;
    else if (adv) p <= (win == 2'(N_REQ - 1)) ? '0 : win + 2'd1;
endmodule

// File: rtl/alu_job_scheduler.sv
// alu_job_scheduler: round-robin ALU job sequencer; req_*/resp_* requester side, M_* slave bus, busy; ALU_SCHED_TIMEOUT_EN adds a poll timeout
module alu_job_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*32-1:0] req_opa,
  input  logic [N_REQ*32-1:0] req_opb,
  input  logic [N_REQ*4-1:0] req_opcode,
  output logic [N_REQ-1:0]   req_grant,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [63:0]        resp_result,
  output logic               resp_err,
  output logic               busy,
  output logic               M_sel,
  output logic               M_wr,
  output logic [7:0]         M_addr,
  output logic [31:0]        M_dout,
  input  logic [31:0]        M_din
);
  state_t state, nxt;
  logic [N_REQ-1:0] arb_grant, sel_q;
  logic any_req, grant_now, tmo;
  logic [31:0] opa_q, opb_q, cap_a, cap_b;
  logic [3:0] opc_q, cap_op;
  logic [63:0] res_q;
  logic [2:0] ofs;
  // grant is gated by reset_n so nothing is promised to a requester while the block is held in reset
  assign grant_now = reset_n && state == IDLE && any_req;
  assign req_grant = grant_now ? arb_grant : '0;
  assign busy = state != IDLE;
  assign resp_result = res_q;
  assign M_addr = BASE_ADDR | {5'b0, ofs};
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk(clk), .reset_n(reset_n), .req(req_valid), .adv(grant_now), .grant(arb_grant), .any(any_req)
  );
  always_comb begin
    cap_a = '0;
    cap_b = '0;
    cap_op = '0;
    for (int i = 0; i < N_REQ; i++)
      if (arb_grant[i]) begin
        cap_a = req_opa[i*32 +: 32];
        cap_b = req_opb[i*32 +: 32];
        cap_op = req_opcode[i*4 +: 4];
      end
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    M_sel = 1'b0;
    M_wr = 1'b0;
    ofs = OFS_A;
    M_dout = '0;
    case (state)
      IDLE: nxt = any_req ? WR_A : IDLE;
      WR_A: begin M_sel = 1'b1; M_wr = 1'b1; ofs = OFS_A; M_dout = opa_q; nxt = WR_B; end
      WR_B: begin M_sel = 1'b1; M_wr = 1'b1; ofs = OFS_B; M_dout = opb_q; nxt = WR_OP; end
      WR_OP: begin M_sel = 1'b1; M_wr = 1'b1; ofs = OFS_OP; M_dout = {28'b0, opc_q}; nxt = WR_START; end
      WR_START: begin M_sel = 1'b1; M_wr = 1'b1; ofs = OFS_START; M_dout = 32'h1; nxt = POLL; end
      POLL: begin M_sel = 1'b1; ofs = OFS_DONE; nxt = M_din[1:0] == DONE_FIN ? RD_LO : tmo ? CLR : POLL; end
      RD_LO: begin M_sel = 1'b1; ofs = OFS_RLO; nxt = opc_q == OPC_MUL ? RD_HI : CLR; end
      RD_HI: begin M_sel = 1'b1; ofs = OFS_RHI; nxt = CLR; end
      CLR: begin M_sel = 1'b1; M_wr = 1'b1; ofs = OFS_CLR; M_dout = 32'h1; nxt = RESP; end
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      opa_q <= '0;
      opb_q <= '0;
      opc_q <= '0;
      sel_q <= '0;
      res_q <= '0;
      resp_valid <= '0;
    end else begin
      resp_valid <= state == CLR ? sel_q : '0;
      if (grant_now) begin
        opa_q <= cap_a;
        opb_q <= cap_b;
        opc_q <= cap_op;
        sel_q <= arb_grant;
        res_q <= '0;
      end
      if (state == RD_LO) res_q <= {32'b0, M_din};
      if (state == RD_HI) res_q[63:32] <= M_din;
      if (tmo) res_q <= '0;
    end
`ifdef ALU_SCHED_TIMEOUT_EN
  logic [15:0] cnt;
  logic err_q;
  // cnt is 0 in the first POLL cycle, so the last allowed poll is TIMEOUT_CYCLES-1
  assign tmo = state == POLL && M_din[1:0] != DONE_FIN && cnt == 16'(TIMEOUT_CYCLES - 1);
  assign resp_err = err_q;
  always_ff @(posedge clk) begin
    cnt <= (!reset_n || state != POLL) ? '0 : cnt + 16'd1;
    err_q <= (!reset_n || grant_now) ? 1'b0 : tmo ? 1'b1 : err_q;
  end
`else
  assign tmo = 1'b0;
  assign resp_err = 1'b0;
`endif
endmodule
